// File: rtl/spi_frame_sequencer_if.sv
// Groups the command/status handshake and the logical SPI lines of the frame sequencer.
// The master is the DAC control side; the slave is the sequencer itself.
interface spi_frame_sequencer_if #(
  parameter int unsigned DATA_WIDTH    = 24,
  parameter int unsigned CLK_DIV_WIDTH = 8,
  parameter int unsigned NUM_CS        = 1
);
  logic                     start;
  logic                     ready;
  logic [DATA_WIDTH-1:0]    data_in;
  logic [CLK_DIV_WIDTH-1:0] clk_div;
  logic                     cpha;
  logic                     lsb_first;
  logic [NUM_CS-1:0]        cs_sel;
  logic                     sdi;
  logic                     sck_next;
  logic                     cs_next;
  logic                     sdo;
  logic [NUM_CS-1:0]        cs_val;
  logic                     slave_en;
  logic                     busy;
  logic                     done;
  logic [DATA_WIDTH-1:0]    rx_data;

  modport master (
    output start, data_in, clk_div, cpha, lsb_first, cs_sel, sdi,
    input  ready, sck_next, cs_next, sdo, cs_val, slave_en, busy, done, rx_data
  );

  modport slave (
    input  start, data_in, clk_div, cpha, lsb_first, cs_sel, sdi,
    output ready, sck_next, cs_next, sdo, cs_val, slave_en, busy, done, rx_data
  );
endinterface

// File: rtl/spi_frame_sequencer.sv
// Serialises one word per SPI frame (SETUP, 2N half-periods of SHIFT, HOLD, GAP) in logical
// polarity and captures the read-back word; every output is a flop fed from next-state values.
module spi_frame_sequencer #(
  parameter int unsigned DATA_WIDTH    = 24,
  parameter int unsigned CLK_DIV_WIDTH = 8,
  parameter int unsigned NUM_CS        = 1
) (
  input  logic                CLK100MHZ,
  input  logic                resetn,
  spi_frame_sequencer_if.slave bus
);

  localparam int unsigned HALF_W = $clog2(2 * DATA_WIDTH);
  localparam int unsigned BIT_W  = $clog2(DATA_WIDTH);
  localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(2 * DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_e;

  state_e                   state_q, state_d;
  logic [CLK_DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [HALF_W-1:0]        half_q, half_d;
  logic [CLK_DIV_WIDTH-1:0] div_q, div_d;
  logic                     cpha_q, cpha_d;
  logic                     lsb_q, lsb_d;
  logic [DATA_WIDTH-1:0]    tx_q, tx_d;
  logic [DATA_WIDTH-1:0]    rx_shift_q, rx_shift_d;
  logic [NUM_CS-1:0]        cs_val_q, cs_val_d;
  logic                     sck_q, sck_d;
  logic                     cs_q, cs_d;
  logic                     sdo_q, sdo_d;
  logic [DATA_WIDTH-1:0]    rx_data_q, rx_data_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     ready_q, ready_d;
  logic                     slave_en_q, slave_en_d;

  logic                     accept;
  logic                     half_last;
  logic [BIT_W-1:0]         tx_bit;

  // Wire position of the k-th transmitted (or received) bit.
  function automatic logic [BIT_W-1:0] bit_pos(input logic lsb, input logic [BIT_W-1:0] k);
    return lsb ? k : LAST_BIT - k;
  endfunction

  // Next-state logic: sequencing, parameter latch and read-back assembly.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    half_d     = half_q;
    div_d      = div_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    tx_d       = tx_q;
    rx_shift_d = rx_shift_q;
    cs_val_d   = cs_val_q;
    accept     = bus.start && ready_q;
    half_last  = (cnt_q == div_q);

    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SETUP;
      ST_SETUP: if (half_last) state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (half_last && (half_q[0] == cpha_q)) begin
          rx_shift_d[bit_pos(lsb_q, BIT_W'(half_q >> 1))] = bus.sdi;
        end
        if (half_last && (half_q == LAST_HALF)) state_d = ST_HOLD;
      end
      ST_HOLD:  if (half_last) state_d = ST_GAP;
      // ready is already high in the final GAP cycle, so a waiting start chains straight on
      ST_GAP:   if (half_last) state_d = accept ? ST_SETUP : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (state_q == ST_IDLE || half_last) cnt_d = '0;
    else                                 cnt_d = cnt_q + CLK_DIV_WIDTH'(1);

    if (state_q != ST_SHIFT) half_d = '0;
    else if (half_last)      half_d = half_q + HALF_W'(1);

    if (accept) begin
      div_d    = bus.clk_div;
      cpha_d   = bus.cpha;
      lsb_d    = bus.lsb_first;
      tx_d     = bus.data_in;
      cs_val_d = bus.cs_sel;
    end
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    tx_bit = '0;
    sdo_d  = 1'b0;
    if (cpha_d)                  tx_bit = BIT_W'(half_d >> 1);
    else if (half_d == LAST_HALF) tx_bit = LAST_BIT;
    else                         tx_bit = BIT_W'((half_d + HALF_W'(1)) >> 1);

    case (state_d)
      ST_SETUP: sdo_d = tx_d[bit_pos(lsb_d, '0)];
      ST_SHIFT: sdo_d = tx_d[bit_pos(lsb_d, tx_bit)];
      ST_HOLD:  sdo_d = tx_d[bit_pos(lsb_d, LAST_BIT)];
      default:  sdo_d = 1'b0;
    endcase

    done_d     = (state_d == ST_GAP) && (cnt_d == div_d);
    ready_d    = (state_d == ST_IDLE) || done_d;
    busy_d     = !ready_d;
    slave_en_d = ready_d;
    sck_d      = (state_d == ST_SHIFT) && !half_d[0];
    cs_d       = state_d inside {ST_SETUP, ST_SHIFT, ST_HOLD};
    rx_data_d  = done_d ? rx_shift_d : rx_data_q;
  end

  always_ff @(posedge CLK100MHZ or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      half_q     <= '0;
      div_q      <= '0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      tx_q       <= '0;
      rx_shift_q <= '0;
      cs_val_q   <= '0;
      sck_q      <= 1'b0;
      cs_q       <= 1'b0;
      sdo_q      <= 1'b0;
      rx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
      slave_en_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      div_q      <= div_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
      tx_q       <= tx_d;
      rx_shift_q <= rx_shift_d;
      cs_val_q   <= cs_val_d;
      sck_q      <= sck_d;
      cs_q       <= cs_d;
      sdo_q      <= sdo_d;
      rx_data_q  <= rx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      slave_en_q <= slave_en_d;
    end
  end

  assign bus.sck_next = sck_q;
  assign bus.cs_next  = cs_q;
  assign bus.sdo      = sdo_q;
  assign bus.cs_val   = cs_val_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.ready    = ready_q;
  assign bus.slave_en = slave_en_q;

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Scoreboard bench for spi_frame_sequencer: directed frames push hand-computed expectations,
// a negedge monitor measures each frame and checks it when done pulses.
module tb_spi_frame_sequencer;

  localparam int unsigned DW  = 24;
  localparam int unsigned CW  = 8;
  localparam int unsigned NCS = 1;

  typedef struct {
    logic [DW-1:0]  seq;
    logic [DW-1:0]  rx;
    logic           cpha;
    logic [NCS-1:0] cs_val;
    int             lat;
    int             cshi;
    int             spacing;
    int             h;
  } exp_t;

  logic clk;
  logic rst_n;
  logic loop_en;
  logic ext_sdi;
  int   cyc;
  int   checks;
  int   errors;
  exp_t q[$];

  spi_frame_sequencer_if #(.DATA_WIDTH(DW), .CLK_DIV_WIDTH(CW), .NUM_CS(NCS)) bus ();

  spi_frame_sequencer #(.DATA_WIDTH(DW), .CLK_DIV_WIDTH(CW), .NUM_CS(NCS)) dut (
    .CLK100MHZ (clk),
    .resetn    (rst_n),
    .bus       (bus.slave)
  );

  assign bus.sdi = loop_en ? bus.sdo : ext_sdi;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sck"},      64'(bus.sck_next), 64'(0));
    chk({tag, "_cs"},       64'(bus.cs_next),  64'(0));
    chk({tag, "_sdo"},      64'(bus.sdo),      64'(0));
    chk({tag, "_busy"},     64'(bus.busy),     64'(0));
    chk({tag, "_done"},     64'(bus.done),     64'(0));
    chk({tag, "_ready"},    64'(bus.ready),    64'(1));
    chk({tag, "_slave_en"}, 64'(bus.slave_en), 64'(1));
    chk({tag, "_rx_data"},  64'(bus.rx_data),  64'(0));
    chk({tag, "_cs_val"},   64'(bus.cs_val),   64'(0));
  endtask

  // Push the expectation, present the command and raise start (one cycle unless held).
  task automatic issue(input logic [DW-1:0] d, input logic [CW-1:0] div, input logic ph,
                       input logic lsb, input logic [NCS-1:0] cs, input logic [DW-1:0] seq,
                       input logic [DW-1:0] rx, input int lat, input int cshi,
                       input int spacing, input bit hold);
    exp_t e;
    e.seq = seq; e.rx = rx; e.cpha = ph; e.cs_val = cs;
    e.lat = lat; e.cshi = cshi; e.spacing = spacing; e.h = int'(div) + 1;
    q.push_back(e);
    bus.data_in = d; bus.clk_div = div; bus.cpha = ph; bus.lsb_first = lsb; bus.cs_sel = cs;
    bus.start = 1'b1;
    if (!hold) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((q.size() != 0 || !bus.ready) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL wait_idle: timeout after %0d cycles, %0d frames pending", n, q.size());
    end
  endtask

  // Monitor state
  bit            in_frame, have_prev, sck_prev, cs_prev;
  int            t_acc, edges, sp_bad, last_rise, cs_hi, low_run, prev_h;
  logic [DW-1:0] got_seq;
  exp_t          cur, e_done;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 0; have_prev = 0; sck_prev = 0; cs_prev = 0; low_run = 0;
    end else begin
      if (in_frame) begin
        if (bus.sck_next && !sck_prev) begin
          if (edges > 0 && (cyc - last_rise) != cur.spacing) sp_bad++;
          last_rise = cyc;
          edges++;
          if (!cur.cpha) got_seq = {got_seq[DW-2:0], bus.sdo};
        end
        if (!bus.sck_next && sck_prev && cur.cpha) got_seq = {got_seq[DW-2:0], bus.sdo};
        if (bus.cs_next) cs_hi++;
      end
      if (bus.cs_next && !cs_prev && have_prev)
        chk("cs_gap_ge_h", 64'(low_run >= prev_h), 64'(1));
      low_run = bus.cs_next ? 0 : low_run + 1;

      if (bus.done) begin
        if (q.size() == 0 || !in_frame) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected no frame in flight (cycle %0d)", cyc);
        end else begin
          e_done = q.pop_front();
          chk("latency",     64'(cyc - t_acc),  64'(e_done.lat));
          chk("rx_data",     64'(bus.rx_data),  64'(e_done.rx));
          chk("sdo_seq",     64'(got_seq),      64'(e_done.seq));
          chk("sck_edges",   64'(edges),        64'(DW));
          chk("sck_spacing", 64'(sp_bad),       64'(0));
          chk("cs_high",     64'(cs_hi),        64'(e_done.cshi));
          chk("cs_val",      64'(bus.cs_val),   64'(e_done.cs_val));
          chk("ready_done",  64'(bus.ready),    64'(1));
          chk("busy_done",   64'(bus.busy),     64'(0));
          have_prev = 1;
          prev_h = e_done.h;
        end
        in_frame = 0;
      end

      if (bus.start && bus.ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_accept: got accept expected none (cycle %0d)", cyc);
        end else begin
          cur = q[0];
          in_frame = 1; t_acc = cyc; edges = 0; sp_bad = 0; cs_hi = 0; got_seq = '0;
        end
      end
      sck_prev = bus.sck_next;
      cs_prev  = bus.cs_next;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; checks = 0; errors = 0;
    rst_n = 1'b0; loop_en = 1'b0; ext_sdi = 1'b0;
    bus.start = 1'b0; bus.data_in = '0; bus.clk_div = '0; bus.cpha = 1'b0;
    bus.lsb_first = 1'b0; bus.cs_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Mode 0, MSB first, sdi tied high
    ext_sdi = 1'b1;
    issue(24'hA5C3F0, 8'd4, 1'b0, 1'b0, 1'b1, 24'hA5C3F0, 24'hFFFFFF, 255, 250, 10, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("mid_busy",     64'(bus.busy),     64'(1));
    chk("mid_ready",    64'(bus.ready),    64'(0));
    chk("mid_slave_en", 64'(bus.slave_en), 64'(0));
    chk("mid_cs_val",   64'(bus.cs_val),   64'(1));
    wait_idle(400);

    // cpha=1, LSB first, loopback
    loop_en = 1'b1;
    issue(24'h123456, 8'd1, 1'b1, 1'b1, 1'b1, 24'h6A2C48, 24'h123456, 102, 100, 4, 0);
    wait_idle(300);

    // Busy rejection, post-accept input changes, back-to-back via held start
    issue(24'h3C5A96, 8'd2, 1'b0, 1'b0, 1'b1, 24'h3C5A96, 24'h3C5A96, 153, 150, 6, 0);
    bus.data_in = 24'h0F0F0F; bus.clk_div = 8'd7; bus.cpha = 1'b1; bus.lsb_first = 1'b1;
    bus.cs_sel = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    issue(24'h5A0FF1, 8'd1, 1'b1, 1'b0, 1'b0, 24'h5A0FF1, 24'h5A0FF1, 102, 100, 4, 1);
    begin
      int n = 0;
      while (!bus.done && n < 300) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 300) begin
        checks++; errors++;
        $display("FAIL b2b_wait: no done within %0d cycles", n);
      end
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle(300);

    // Reset during SHIFT at h=10 (H=2: SETUP 2 cycles, then 10 half-periods)
    issue(24'hAAAAAA, 8'd1, 1'b0, 1'b0, 1'b1, 24'hAAAAAA, 24'hAAAAAA, 102, 100, 4, 0);
    repeat (22) @(posedge clk);
    #1;
    chk("pre_reset_sck", 64'(bus.sck_next), 64'(1));
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    issue(24'hFFFFFF, 8'd3, 1'b0, 1'b0, 1'b1, 24'hFFFFFF, 24'hFFFFFF, 204, 200, 8, 0);
    wait_idle(400);

    // clk_div=0: SCK toggles every cycle
    issue(24'h000001, 8'd0, 1'b0, 1'b0, 1'b1, 24'h000001, 24'h000001, 51, 50, 2, 0);
    wait_idle(200);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", 64'(q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
